// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment display.
// Glyphs are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational hex nibble to active-low 7-segment glyph.
// Output bit order is {g,f,e,d,c,b,a}.
module decodificador_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH[nib_i];
  end

endmodule

// File: rtl/control_display_7seg.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous update.
// Define SEG_LEADING_ZERO_BLANK_EN to darken leading zero digits.
module control_display_7seg
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 10
) (
  input  logic                  clk_10MHz_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   enable_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = 4 * N_DIGITS;

  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DW-1:0]        shadow_data_q, shadow_data_d;
  logic [N_DIGITS-1:0]  shadow_dp_q, shadow_dp_d;
  logic [DW-1:0]        active_data_q, active_data_d;
  logic [N_DIGITS-1:0]  active_dp_q, active_dp_d;
  logic [N_DIGITS-1:0]  an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 frame_q, frame_d;

  logic                 tick;
  logic                 wrap;
  logic                 lz_ok;
  logic [3:0]           nib;
  logic [6:0]           glyph;

  assign tick = (cnt_q == CNT_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);
  assign nib  = active_data_q[{idx_q, 2'b00} +: 4];

  decodificador_7seg u_dec (
    .nib_i (nib),
    .seg_o (glyph)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int k = 1; k < N_DIGITS; k++) begin
      if (active_data_q[4*k +: 4] != 4'h0) msd = IW'(k);
    end
  end

  assign lz_ok = (idx_q <= msd);
`else
  assign lz_ok = 1'b1;
`endif

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_BLANK: if (cnt_q == BLANK_LAST) state_d = S_SHOW;
      S_SHOW:  if (tick) state_d = S_BLANK;
      default: state_d = S_BLANK;
    endcase
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
  end

  // A write landing on the wrap edge bypasses the shadow so it is never lost.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    if (we_i) begin
      shadow_data_d = data_i;
      shadow_dp_d   = dp_i;
    end
    if (wrap) begin
      active_data_d = we_i ? data_i : shadow_data_q;
      active_dp_d   = we_i ? dp_i   : shadow_dp_q;
    end
  end

  always_comb begin
    an_d    = '1;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    frame_d = wrap;
    if (state_q == S_SHOW && enable_i[idx_q] && lz_ok) begin
      an_d[idx_q] = 1'b0;
      seg_d       = glyph;
      dp_d        = ~active_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk_10MHz_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_q       <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: doc/control_display_7seg.md
CONTROL_DISPLAY_7SEG -- requirements
Module: control_display_7seg

Interface
REQ-001 Parameter N_DIGITS, default 8, number of multiplexed digits.
REQ-002 Parameter PRESCALE, default 1000, clk_10MHz_i cycles per digit slot (100 us slot at 10 MHz).
REQ-003 Parameter BLANK_CYCLES, default 10, cycles of anode blanking at the start of each slot.
REQ-004 clk_10MHz_i  in  1  single 10 MHz clock; all state on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-low reset.
REQ-006 we_i  in  1  write strobe from processor bus, one cycle per write.
REQ-007 data_i  in  4*N_DIGITS  hex value to display; nibble k drives digit k.
REQ-008 dp_i  in  N_DIGITS  decimal point per digit, captured with data_i on we_i.
REQ-009 enable_i  in  N_DIGITS  per-digit enable mask, sampled live.
REQ-010 an_o  out  N_DIGITS  anode selects, active-low, registered.
REQ-011 seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 dp_o  out  1  decimal point, active-low, registered.
REQ-013 frame_o  out  1  one-cycle pulse when digit index wraps N_DIGITS-1 -> 0.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 and wrap; slot tick asserted when count == PRESCALE-1.
REQ-015 FSM states SHALL be S_BLANK and S_SHOW; reset state S_BLANK, digit index 0.
REQ-016 S_BLANK SHALL last exactly BLANK_CYCLES cycles from slot start, an_o = all ones, then go to S_SHOW.
REQ-017 S_SHOW SHALL drive an_o bit [index] low, seg_o = decode(active nibble[index]), dp_o = ~active_dp[index], until slot tick.
REQ-018 On slot tick the FSM SHALL return to S_BLANK and index SHALL increment, wrapping N_DIGITS-1 -> 0.
REQ-019 A digit with enable_i[index] = 0 SHALL keep all anodes high for its whole slot; slot timing unchanged.
REQ-020 we_i SHALL load data_i/dp_i into a shadow register on the same edge.
REQ-021 Shadow SHALL be copied to the active register only on the wrap edge (frame boundary); mid-frame writes never change displayed data.
REQ-022 we_i coincident with the wrap edge SHALL load data_i/dp_i directly into both shadow and active (newest wins).
REQ-023 Outputs SHALL lag FSM state by exactly one cycle (registered pins).
REQ-024 Decode SHALL map 0-F to standard hex glyphs; '0' = 7'b1000000, '7' = 7'b1111000, 'A' = 7'b0001000, '5' = 7'b0010010.

Reset
REQ-025 rst_i low SHALL immediately force an_o = all ones, seg_o = 7'h7F, dp_o = 1, frame_o = 0, independent of clock.
REQ-026 Reset SHALL clear prescaler, index, shadow, active; asserted mid-slot it aborts the slot with no glitch to low anodes.
REQ-027 After rst_i release, first S_SHOW on digit 0 SHALL begin BLANK_CYCLES cycles later.

Configuration
REQ-028 Macro SEG_LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero nibble of active SHALL be treated as disabled (digit 0 always shown).
REQ-029 Macro undefined: all enabled digits SHALL show their nibble, zeros included; no suppression logic synthesized.

Structure
REQ-030 Package seg7_pkg SHALL hold the state enum typedef, glyph constant table, and SEG_OFF = 7'h7F.
REQ-031 Sub-module decodificador_7seg SHALL be the combinational nibble-to-glyph decoder.

Verification
REQ-032 Pull rst_i low mid-S_SHOW -> an_o = 8'hFF, seg_o = 7'h7F before next clock edge; index 0 after release.
REQ-033 Write 32'h0123_4567, run past wrap -> slot 0 shows '7' (7'b1111000), slot 7 shows '0' (7'b1000000).
REQ-034 Write 32'hFFFF_FFFF mid-frame -> old digits persist until frame_o, new value from next slot 0.
REQ-035 enable_i = 8'b0000_0001 over two frames -> only an_o[0] ever low, slot period still 1000 cycles.
REQ-036 Measure slot -> an_o high exactly 10 cycles after each index change, low 990 cycles, frame_o every 8000 cycles.
REQ-037 Data 32'h0000_00A5 -> with macro, digits 2-7 dark; without macro, digits 2-7 show '0'.
